// File: rtl/fp_sub_arbiter.sv
// Round-robin front end that shares one combinational single-precision subtractor
// between two requesters. Results are returned through a held valid/ready register.

module fp_subtractor (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] diff
);
  logic [31:0] bn, x, y;
  logic        a_nan, b_nan, a_inf, b_inf, same, inc;
  logic [7:0]  ex, ey, d, sh, ef;
  logic [23:0] mx, my;
  logic [49:0] y_sh;
  logic [26:0] my_al, m27;
  logic [27:0] s;
  logic [4:0]  lz;
  logic [8:0]  e9;
  logic [30:0] mag;

  function automatic logic [4:0] lzc27(input logic [26:0] v);
    lzc27 = 5'd27;
    for (int i = 0; i < 27; i++)
      if (v[i]) lzc27 = 5'(26 - i);
  endfunction

  // Computes a + (-b): x is the larger magnitude, y is aligned to it with a sticky bit.
  always_comb begin
    bn    = {~b[31], b[30:0]};
    a_nan = (&a[30:23]) & (|a[22:0]);
    b_nan = (&b[30:23]) & (|b[22:0]);
    a_inf = (&a[30:23]) & ~(|a[22:0]);
    b_inf = (&b[30:23]) & ~(|b[22:0]);
    if (bn[30:0] > a[30:0]) begin
      x = bn;
      y = a;
    end else begin
      x = a;
      y = bn;
    end
    ex    = (x[30:23] == 8'd0) ? 8'd1 : x[30:23];
    ey    = (y[30:23] == 8'd0) ? 8'd1 : y[30:23];
    mx    = {|x[30:23], x[22:0]};
    my    = {|y[30:23], y[22:0]};
    d     = ex - ey;
    y_sh  = {my, 26'd0} >> d;
    my_al = {y_sh[49:24], |y_sh[23:0]};
    same  = (x[31] == y[31]);
    s     = same ? ({1'b0, mx, 3'b000} + {1'b0, my_al})
                 : ({1'b0, mx, 3'b000} - {1'b0, my_al});
    lz    = lzc27(s[26:0]);
    if (s[27]) begin
      sh  = 8'd0;
      m27 = {s[27:2], s[1] | s[0]};
      e9  = {1'b0, ex} + 9'd1;
    end else begin
      // Left shift stops at the minimum exponent so tiny results come out subnormal.
      sh  = ({3'b000, lz} < ex) ? {3'b000, lz} : ex - 8'd1;
      m27 = s[26:0] << sh;
      e9  = {1'b0, ex} - {1'b0, sh};
    end
    ef  = m27[26] ? e9[7:0] : 8'd0;
    inc = m27[2] & (m27[3] | m27[1] | m27[0]);
    mag = {ef, m27[25:3]} + {30'd0, inc};
    if (a_nan || b_nan || (a_inf && b_inf && (a[31] != bn[31])))
      diff = 32'h7FC0_0000;
    else if (a_inf)
      diff = a;
    else if (b_inf)
      diff = bn;
    else if (s == 28'd0)
      diff = {same & x[31], 31'd0};
    else if (e9 >= 9'd255)
      diff = {x[31], 8'hFF, 23'd0};
    else
      diff = {x[31], mag};
  end
endmodule

module fp_sub_arbiter #(
  parameter int EXEC_CYCLES = 1,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic             req0_op,
  input  logic [31:0]      req0_a,
  input  logic [31:0]      req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic             req1_op,
  input  logic [31:0]      req1_a,
  input  logic [31:0]      req1_b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [31:0]      res_data,
  output logic             res_id,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);
  localparam int EW = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state_reg;
  logic             ptr_reg, id_reg, res_valid_reg, res_id_reg, busy_reg;
  logic [EW-1:0]    cnt_reg;
  logic [31:0]      op_a_reg, op_b_reg, res_data_reg, diff;
  logic [CNT_W-1:0] op_count_reg;
  logic [1:0]       req_valid, req_op, gnt;
  logic [31:0]      req_a [2];
  logic [31:0]      req_b [2];
  logic [31:0]      b_eff [2];
  logic             sel;

  assign req_valid = {req1_valid, req0_valid};
  assign req_op    = {req1_op, req0_op};
  assign req_a[0]  = req0_a;
  assign req_a[1]  = req1_a;
  assign req_b[0]  = req0_b;
  assign req_b[1]  = req1_b;

  // A requester wins when it is alone or when the pointer names it.
  for (genvar gi = 0; gi < 2; gi++) begin : g_req
    assign gnt[gi]   = req_valid[gi] & (~req_valid[1-gi] | (ptr_reg == 1'(gi)));
    assign b_eff[gi] = req_op[gi] ? {~req_b[gi][31], req_b[gi][30:0]} : req_b[gi];
  end

  assign sel        = gnt[1];
  assign req0_ready = gnt[0] & rst_n & (state_reg == IDLE);
  assign req1_ready = gnt[1] & rst_n & (state_reg == IDLE);

  fp_subtractor u_sub (
    .a    (op_a_reg),
    .b    (op_b_reg),
    .diff (diff)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      ptr_reg       <= 1'b0;
      id_reg        <= 1'b0;
      cnt_reg       <= '0;
      op_a_reg      <= '0;
      op_b_reg      <= '0;
      res_valid_reg <= 1'b0;
      res_data_reg  <= '0;
      res_id_reg    <= 1'b0;
      busy_reg      <= 1'b0;
      op_count_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (|gnt) begin
            op_a_reg  <= req_a[sel];
            op_b_reg  <= b_eff[sel];
            id_reg    <= sel;
            ptr_reg   <= ~sel;
            cnt_reg   <= EW'(EXEC_CYCLES - 1);
            busy_reg  <= 1'b1;
            state_reg <= EXEC;
          end
        end
        EXEC: begin
          if (cnt_reg != '0) begin
            cnt_reg <= cnt_reg - 1'b1;
          end else begin
            res_data_reg  <= diff;
            res_id_reg    <= id_reg;
            res_valid_reg <= 1'b1;
            state_reg     <= RESP;
          end
        end
        RESP: begin
          if (res_valid_reg && res_ready) begin
            res_valid_reg <= 1'b0;
            op_count_reg  <= op_count_reg + 1'b1;
            busy_reg      <= 1'b0;
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign res_valid = res_valid_reg;
  assign res_data  = res_data_reg;
  assign res_id    = res_id_reg;
  assign busy      = busy_reg;
  assign op_count  = op_count_reg;
endmodule
